// File: rtl/cursor_xy_if.sv
// -----------------------------------------------------------------------------
// cursor_xy_if
//   Bundle of the control and status signals exchanged between the button /
//   debounce logic (master) and the cursor_xy position counter (slave).
//   Widths follow the row/col extents so the same interface parameters must
//   be used on both sides.
//
//   Ports (signals):
//     fire      step request (level; rising edge = one step)
//     row_en    step applies to the row axis
//     col_en    step applies to the col axis
//     add_n     0 = increment, 1 = decrement
//     load      synchronous load of load_row / load_col
//     load_row  row value to load
//     load_col  col value to load
//     row/col   current position (registered)
//     row_hot   one-hot decode of row
//     col_hot   one-hot decode of col
//     moved     1-cycle pulse: an axis changed value
//     limit     1-cycle pulse: saturating step blocked at an end
// -----------------------------------------------------------------------------
interface cursor_xy_if #(
    parameter int NUM_ROWS = 4,
    parameter int NUM_COLS = 4
);
    localparam int RW = $clog2(NUM_ROWS);
    localparam int CW = $clog2(NUM_COLS);

    logic                fire;
    logic                row_en;
    logic                col_en;
    logic                add_n;
    logic                load;
    logic [RW-1:0]       load_row;
    logic [CW-1:0]       load_col;
    logic [RW-1:0]       row;
    logic [CW-1:0]       col;
    logic [NUM_ROWS-1:0] row_hot;
    logic [NUM_COLS-1:0] col_hot;
    logic                moved;
    logic                limit;

    modport master (
        output fire, row_en, col_en, add_n, load, load_row, load_col,
        input  row, col, row_hot, col_hot, moved, limit
    );

    modport slave (
        input  fire, row_en, col_en, add_n, load, load_row, load_col,
        output row, col, row_hot, col_hot, moved, limit
    );
endinterface

// File: rtl/cursor_xy.sv
// -----------------------------------------------------------------------------
// cursor_xy
//   Two-axis cursor position counter feeding the VDC select lines. Each axis
//   counts over an arbitrary extent 0..NUM_x-1 and either wraps or saturates.
//   A rising edge of fire produces one step; with REPEAT_DLY > 0 a held fire
//   also produces repeat steps (first after REPEAT_DLY cycles, then every
//   REPEAT_PER cycles). load overrides stepping and clamps out-of-range values.
//
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous reset, active low
//     bus    cursor_xy_if.slave: step/load controls in, position/status out
// -----------------------------------------------------------------------------
module cursor_xy #(
    parameter int NUM_ROWS   = 4,
    parameter int NUM_COLS   = 4,
    parameter int RST_ROW    = 0,
    parameter int RST_COL    = 0,
    parameter int WRAP       = 1,
    parameter int REPEAT_DLY = 0,
    parameter int REPEAT_PER = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    cursor_xy_if.slave bus
);
    localparam int RW = $clog2(NUM_ROWS);
    localparam int CW = $clog2(NUM_COLS);

    localparam logic [RW-1:0] ROW_MAX = RW'(NUM_ROWS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(NUM_COLS - 1);
    localparam logic [RW-1:0] ROW_RST = RW'(RST_ROW);
    localparam logic [CW-1:0] COL_RST = CW'(RST_COL);

    logic [RW-1:0] row_q, row_n, row_ld;
    logic [CW-1:0] col_q, col_n, col_ld;
    logic          fire_ff;
    logic          moved_q, moved_n;
    logic          limit_q, limit_n;
    logic          rise;
    logic          rpt_tick;
    logic          step;

    assign rise = bus.fire & ~fire_ff;
    assign step = rise | rpt_tick;

    // Hold-to-repeat timer. It restarts on every rising edge and whenever fire
    // drops; rpt_on selects between the initial delay and the repeat period.
    generate
        if (REPEAT_DLY > 0) begin : g_repeat
            localparam int RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
            localparam int RPW     = $clog2(RPT_MAX + 1);

            logic [RPW-1:0] rpt_cnt;
            logic [RPW-1:0] cnt_inc;
            logic           rpt_on;
            logic           held;

            // fire & fire_ff: fire is high and this is not its rising edge.
            assign held     = bus.fire & fire_ff;
            assign cnt_inc  = rpt_cnt + RPW'(1);
            assign rpt_tick = held &
                (cnt_inc == (rpt_on ? RPW'(REPEAT_PER) : RPW'(REPEAT_DLY)));

            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rpt_cnt <= '0;
                    rpt_on  <= 1'b0;
                end else if (!held) begin
                    rpt_cnt <= '0;
                    rpt_on  <= 1'b0;
                end else if (rpt_tick) begin
                    rpt_cnt <= '0;
                    rpt_on  <= 1'b1;
                end else begin
                    rpt_cnt <= cnt_inc;
                end
            end
        end else begin : g_no_repeat
            assign rpt_tick = 1'b0;
        end
    endgenerate

    // Load clamping; a power-of-two extent cannot be exceeded, so no compare.
    generate
        if (NUM_ROWS == (1 << RW)) begin : g_row_noclamp
            assign row_ld = bus.load_row;
        end else begin : g_row_clamp
            assign row_ld = (bus.load_row > ROW_MAX) ? ROW_MAX : bus.load_row;
        end
        if (NUM_COLS == (1 << CW)) begin : g_col_noclamp
            assign col_ld = bus.load_col;
        end else begin : g_col_clamp
            assign col_ld = (bus.load_col > COL_MAX) ? COL_MAX : bus.load_col;
        end
    endgenerate

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        row_n   = row_q;
        col_n   = col_q;
        moved_n = 1'b0;
        limit_n = 1'b0;

        if (bus.load) begin
            row_n   = row_ld;
            col_n   = col_ld;
            moved_n = (row_ld != row_q) | (col_ld != col_q);
        end else if (step) begin
            // Ends are detected by explicit compare, never by counter overflow.
            if (bus.row_en) begin
                if (!bus.add_n) begin
                    if (row_q != ROW_MAX) row_n = row_q + RW'(1);
                    else if (WRAP != 0)   row_n = '0;
                    else                  limit_n = 1'b1;
                end else begin
                    if (row_q != '0)      row_n = row_q - RW'(1);
                    else if (WRAP != 0)   row_n = ROW_MAX;
                    else                  limit_n = 1'b1;
                end
            end
            if (bus.col_en) begin
                if (!bus.add_n) begin
                    if (col_q != COL_MAX) col_n = col_q + CW'(1);
                    else if (WRAP != 0)   col_n = '0;
                    else                  limit_n = 1'b1;
                end else begin
                    if (col_q != '0)      col_n = col_q - CW'(1);
                    else if (WRAP != 0)   col_n = COL_MAX;
                    else                  limit_n = 1'b1;
                end
            end
            moved_n = (row_n != row_q) | (col_n != col_q);
        end
    end

    // NOTE: only a handful of flops here, all with async reset; there is no
    // storage array that would need to be left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q   <= ROW_RST;
            col_q   <= COL_RST;
            fire_ff <= 1'b0;
            moved_q <= 1'b0;
            limit_q <= 1'b0;
        end else begin
            row_q   <= row_n;
            col_q   <= col_n;
            fire_ff <= bus.fire;
            moved_q <= moved_n;
            limit_q <= limit_n;
        end
    end

    assign bus.row     = row_q;
    assign bus.col     = col_q;
    assign bus.row_hot = NUM_ROWS'(1) << row_q;
    assign bus.col_hot = NUM_COLS'(1) << col_q;
    assign bus.moved   = moved_q;
    assign bus.limit   = limit_q;
endmodule

// File: tb/tb_cursor_xy.sv
// -----------------------------------------------------------------------------
// tb_cursor_xy
//   Three cursor_xy instances driven by the same controls:
//     u0: 4x4, wrap, no repeat
//     u1: 4x5, wrap, no repeat, reset position (1,2)
//     u2: 4x5, saturate, repeat delay 8 / period 4
//   An integer-arithmetic reference model tracks all three every cycle;
//   a vector table and hand sequences add fixed expectations.
// -----------------------------------------------------------------------------
module tb_cursor_xy;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fire = 1'b0, row_en = 1'b0, col_en = 1'b0, add_n = 1'b0, load = 1'b0;
    logic [1:0] load_row = '0;
    logic [2:0] load_col = '0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    cursor_xy_if #(.NUM_ROWS(4), .NUM_COLS(4)) i0 ();
    cursor_xy_if #(.NUM_ROWS(4), .NUM_COLS(5)) i1 ();
    cursor_xy_if #(.NUM_ROWS(4), .NUM_COLS(5)) i2 ();

    assign i0.fire = fire;   assign i1.fire = fire;   assign i2.fire = fire;
    assign i0.row_en = row_en; assign i1.row_en = row_en; assign i2.row_en = row_en;
    assign i0.col_en = col_en; assign i1.col_en = col_en; assign i2.col_en = col_en;
    assign i0.add_n = add_n; assign i1.add_n = add_n; assign i2.add_n = add_n;
    assign i0.load = load;   assign i1.load = load;   assign i2.load = load;
    assign i0.load_row = load_row; assign i1.load_row = load_row; assign i2.load_row = load_row;
    assign i0.load_col = load_col[1:0]; assign i1.load_col = load_col; assign i2.load_col = load_col;

    cursor_xy #(.NUM_ROWS(4), .NUM_COLS(4), .RST_ROW(0), .RST_COL(0), .WRAP(1),
                .REPEAT_DLY(0), .REPEAT_PER(4))
        u0 (.clk(clk), .rst_n(rst_n), .bus(i0));
    cursor_xy #(.NUM_ROWS(4), .NUM_COLS(5), .RST_ROW(1), .RST_COL(2), .WRAP(1),
                .REPEAT_DLY(0), .REPEAT_PER(4))
        u1 (.clk(clk), .rst_n(rst_n), .bus(i1));
    cursor_xy #(.NUM_ROWS(4), .NUM_COLS(5), .RST_ROW(0), .RST_COL(0), .WRAP(0),
                .REPEAT_DLY(8), .REPEAT_PER(4))
        u2 (.clk(clk), .rst_n(rst_n), .bus(i2));

    // ---------------- reference model ----------------
    int m_row[3], m_col[3], m_held[3];
    bit m_fprev[3], m_moved[3], m_limit[3];

    function automatic int cfg_nc(int k);  return (k == 0) ? 4 : 5; endfunction
    function automatic int cfg_wrap(int k); return (k == 2) ? 0 : 1; endfunction
    function automatic int cfg_dly(int k); return (k == 2) ? 8 : 0; endfunction
    function automatic int cfg_rrow(int k); return (k == 1) ? 1 : 0; endfunction
    function automatic int cfg_rcol(int k); return (k == 1) ? 2 : 0; endfunction

    // One step of a single axis over 0..n-1.
    task automatic axis_step(input int v, input int n, input int wrap, input bit dec,
                             output int nv, output bit blk);
        nv  = dec ? v - 1 : v + 1;
        blk = 1'b0;
        if (nv < 0 || nv >= n) begin
            if (wrap != 0) nv = (nv + n) % n;
            else begin nv = v; blk = 1'b1; end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_row[k] = cfg_rrow(k); m_col[k] = cfg_rcol(k); m_held[k] = 0;
            m_fprev[k] = 1'b0; m_moved[k] = 1'b0; m_limit[k] = 1'b0;
        end
    endtask

    task automatic model_update();
        for (int k = 0; k < 3; k++) begin
            bit rise, tick, b1, b2;
            int nr, nc, lr, lc;
            rise = fire && !m_fprev[k];
            if (!fire || rise) m_held[k] = 0; else m_held[k]++;
            tick = fire && !rise && cfg_dly(k) > 0 && m_held[k] >= cfg_dly(k) &&
                   ((m_held[k] - cfg_dly(k)) % 4 == 0);
            m_moved[k] = 1'b0; m_limit[k] = 1'b0;
            nr = m_row[k]; nc = m_col[k]; b1 = 1'b0; b2 = 1'b0;
            if (load) begin
                lr = int'(load_row);
                lc = (k == 0) ? int'(load_col) % 4 : int'(load_col);
                if (lc > cfg_nc(k) - 1) lc = cfg_nc(k) - 1;
                nr = lr; nc = lc;
            end else if (rise || tick) begin
                if (row_en) axis_step(m_row[k], 4, cfg_wrap(k), add_n, nr, b1);
                if (col_en) axis_step(m_col[k], cfg_nc(k), cfg_wrap(k), add_n, nc, b2);
                m_limit[k] = b1 || b2;
            end
            m_moved[k] = (nr != m_row[k]) || (nc != m_col[k]);
            m_row[k] = nr; m_col[k] = nc;
            m_fprev[k] = fire;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (cycle %0d): got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic check_dut(input int k, input logic [31:0] r, input logic [31:0] c,
                             input logic [31:0] rh, input logic [31:0] ch,
                             input logic [31:0] mv, input logic [31:0] lm);
        check($sformatf("u%0d row", k), r, 32'(m_row[k]));
        check($sformatf("u%0d col", k), c, 32'(m_col[k]));
        check($sformatf("u%0d row_hot", k), rh, 32'(1) << m_row[k]);
        check($sformatf("u%0d col_hot", k), ch, 32'(1) << m_col[k]);
        check($sformatf("u%0d moved", k), mv, 32'(m_moved[k]));
        check($sformatf("u%0d limit", k), lm, 32'(m_limit[k]));
    endtask

    task automatic check_all();
        check_dut(0, 32'(i0.row), 32'(i0.col), 32'(i0.row_hot), 32'(i0.col_hot),
                  32'(i0.moved), 32'(i0.limit));
        check_dut(1, 32'(i1.row), 32'(i1.col), 32'(i1.row_hot), 32'(i1.col_hot),
                  32'(i1.moved), 32'(i1.limit));
        check_dut(2, 32'(i2.row), 32'(i2.col), 32'(i2.row_hot), 32'(i2.col_hot),
                  32'(i2.moved), 32'(i2.limit));
    endtask

    // Inputs are stable from the previous falling edge; outputs are compared
    // on the falling edge after the active one.
    task automatic step_clk();
        @(posedge clk);
        model_update();
        @(negedge clk);
        cyc++;
        check_all();
    endtask

    task automatic set_in(input bit f, input bit re, input bit ce, input bit an,
                          input bit ld, input logic [1:0] lr, input logic [2:0] lc);
        fire = f; row_en = re; col_en = ce; add_n = an; load = ld;
        load_row = lr; load_col = lc;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 2'd0, 3'd0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_all();
    endtask

    typedef struct {
        bit         fire, row_en, col_en, add_n, load;
        logic [1:0] load_row;
        logic [2:0] load_col;
        int         exp_row, exp_col;
        bit         exp_moved, exp_limit;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int mv;

        // Vectors for u0 (4x4, wrap), applied in order from reset.
        vecs[0]  = '{1,0,1,0,0, 2'd0,3'd0, 0,1, 1,0};  // rising edge: col +1
        vecs[1]  = '{1,0,1,0,0, 2'd0,3'd0, 0,1, 0,0};  // held: no step
        vecs[2]  = '{0,0,0,0,0, 2'd0,3'd0, 0,1, 0,0};
        vecs[3]  = '{1,1,1,1,0, 2'd0,3'd0, 3,0, 1,0};  // both axes down, row wraps
        vecs[4]  = '{0,0,0,0,0, 2'd0,3'd0, 3,0, 0,0};
        vecs[5]  = '{1,0,0,0,0, 2'd0,3'd0, 3,0, 0,0};  // step with no axis enabled
        vecs[6]  = '{0,0,0,0,0, 2'd0,3'd0, 3,0, 0,0};
        vecs[7]  = '{1,1,0,0,1, 2'd2,3'd3, 2,3, 1,0};  // load wins over step
        vecs[8]  = '{1,1,0,0,0, 2'd0,3'd0, 2,3, 0,0};  // fire already seen high
        vecs[9]  = '{0,0,0,0,1, 2'd2,3'd3, 2,3, 0,0};  // load of same value
        vecs[10] = '{1,0,1,0,0, 2'd0,3'd0, 2,0, 1,0};  // col 3 wraps to 0
        vecs[11] = '{0,0,0,0,0, 2'd0,3'd0, 2,0, 0,0};

        // Reset state.
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_all();
        check("reset u0 row_hot", 32'(i0.row_hot), 32'b0001);
        check("reset u0 col_hot", 32'(i0.col_hot), 32'b0001);

        // Table vectors.
        for (int i = 0; i < 12; i++) begin
            set_in(vecs[i].fire, vecs[i].row_en, vecs[i].col_en, vecs[i].add_n,
                   vecs[i].load, vecs[i].load_row, vecs[i].load_col);
            step_clk();
            check($sformatf("vec%0d row", i), 32'(i0.row), 32'(vecs[i].exp_row));
            check($sformatf("vec%0d col", i), 32'(i0.col), 32'(vecs[i].exp_col));
            check($sformatf("vec%0d moved", i), 32'(i0.moved), 32'(vecs[i].exp_moved));
            check($sformatf("vec%0d limit", i), 32'(i0.limit), 32'(vecs[i].exp_limit));
        end

        // Held fire without repeat: exactly one step.
        do_reset();
        set_in(1, 0, 1, 0, 0, 2'd0, 3'd0);
        mv = 0;
        for (int i = 0; i < 10; i++) begin
            step_clk();
            mv += int'(i0.moved);
        end
        check("hold u0 moved pulses", 32'(mv), 32'd1);
        check("hold u0 col", 32'(i0.col), 32'd1);

        // Non-power-of-two extent: wrap (u1) and saturate (u2) at col 4.
        set_in(0, 0, 0, 0, 1, 2'd0, 3'd4); step_clk();
        set_in(1, 0, 1, 0, 0, 2'd0, 3'd0); step_clk();
        check("wrap5 inc u1 col", 32'(i1.col), 32'd0);
        check("sat5 inc u2 col", 32'(i2.col), 32'd4);
        check("sat5 inc u2 limit", 32'(i2.limit), 32'd1);
        check("sat5 inc u2 moved", 32'(i2.moved), 32'd0);
        set_in(0, 0, 0, 0, 0, 2'd0, 3'd0); step_clk();
        check("sat5 limit pulse ends", 32'(i2.limit), 32'd0);
        set_in(1, 0, 1, 1, 0, 2'd0, 3'd0); step_clk();
        check("wrap5 dec u1 col", 32'(i1.col), 32'd4);
        check("wrap5 dec u1 col_hot", 32'(i1.col_hot), 32'b10000);
        set_in(0, 0, 0, 0, 0, 2'd0, 3'd0); step_clk();

        // Out-of-range load is clamped.
        set_in(0, 0, 0, 0, 1, 2'd1, 3'd7); step_clk();
        check("clamp u1 col", 32'(i1.col), 32'd4);
        check("clamp u2 col", 32'(i2.col), 32'd4);
        set_in(0, 0, 0, 0, 0, 2'd0, 3'd0); step_clk();

        // Hold-to-repeat on u2: steps at edges 0, 8, 12; edge 16 hits the end.
        do_reset();
        set_in(1, 1, 0, 0, 0, 2'd0, 3'd0);
        for (int e = 0; e < 20; e++) begin
            step_clk();
            check($sformatf("rpt e%0d moved", e), 32'(i2.moved),
                  32'(e == 0 || e == 8 || e == 12));
            check($sformatf("rpt e%0d limit", e), 32'(i2.limit), 32'(e == 16));
        end
        check("rpt final row", 32'(i2.row), 32'd3);

        // Async reset while fire stays high, then a fresh rising edge.
        step_clk();
        #2 rst_n = 1'b0;
        #1;
        check("async u2 row", 32'(i2.row), 32'd0);
        check("async u2 row_hot", 32'(i2.row_hot), 32'b0001);
        check("async u1 row", 32'(i1.row), 32'd1);
        check("async u1 col", 32'(i1.col), 32'd2);
        check("async u2 moved", 32'(i2.moved), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step_clk();
        check("post-reset edge u2 moved", 32'(i2.moved), 32'd1);
        check("post-reset edge u2 row", 32'(i2.row), 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 9) == 0) fire = ~fire;
            row_en   = 1'($urandom_range(0, 1));
            col_en   = 1'($urandom_range(0, 1));
            add_n    = 1'($urandom_range(0, 1));
            load     = ($urandom_range(0, 11) == 0);
            load_row = 2'($urandom_range(0, 3));
            load_col = 3'($urandom_range(0, 7));
            step_clk();
        end

        set_in(0, 0, 0, 0, 0, 2'd0, 3'd0);
        step_clk();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
